// File: rtl/gbt_rx_frameclk_phalgnr_dps_ctrl.sv
// Dynamic phase-shift initiator for the RX frame-clock phase-aligner PLL.
// Accepts step requests, pulses phase_en one VCO step at a time, waits for the
// PLL phase_done handshake per step and tracks phase position modulo one
// outclk_0 period.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a request (or finishing a zero-step request)
// ST_ASSERT  | phase_en held high for PHASE_EN_CYCLES
// ST_WAIT_LOW| waiting for synchronised phase_done to fall
// ST_WAIT_HIGH| waiting for synchronised phase_done to rise (step complete)
// ST_GAP     | idle spacing before next step or completion
module gbt_rx_frameclk_phalgnr_dps_ctrl #(
  parameter int STEP_W           = 8,
  parameter int POS_W            = 8,
  parameter int STEPS_PER_PERIOD = 144,
  parameter int PHASE_EN_CYCLES  = 2,
  parameter int GAP_CYCLES       = 2,
  parameter int TIMEOUT_CYCLES   = 1023
) (
  input  logic              scanclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_updn,
  input  logic [4:0]        req_cntsel,
  input  logic [STEP_W-1:0] req_steps,
  output logic              phase_en,
  output logic              updn,
  output logic [4:0]        cntsel,
  input  logic              phase_done,
  output logic              busy,
  output logic              done_pulse,
  output logic              timeout_err,
  output logic              lock_err,
  output logic [POS_W-1:0]  phase_pos
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + PHASE_EN_CYCLES + GAP_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_PE  = TMR_W'(PHASE_EN_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_GAP = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_TO  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(STEPS_PER_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ASSERT, ST_WAIT_LOW, ST_WAIT_HIGH, ST_GAP
  } state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic [STEP_W-1:0] remaining, rem_nxt;
  logic [POS_W-1:0]  pos_nxt, pos_step;
  logic              updn_nxt, busy_nxt, done_nxt, terr_nxt, lerr_nxt;
  logic [4:0]        cntsel_nxt;
  logic              req_ready_q, ready_nxt;
  logic              pd_meta, pd_s;
  logic              accept, tmr_zero;

  // Registered ready is gated by live lock so an unlock blocks acceptance at once.
  assign req_ready = req_ready_q & pll_locked;
  assign phase_en  = (state == ST_ASSERT);
  assign accept    = req_valid & req_ready;
  assign tmr_zero  = (tmr == '0);

  // Two-flop synchroniser for the asynchronous phase_done from the PLL.
  always_ff @(posedge scanclk) begin
    if (rst) begin
      pd_meta <= 1'b1;
      pd_s    <= 1'b1;
    end else begin
      pd_meta <= phase_done;
      pd_s    <= pd_meta;
    end
  end

  // Phase position one step on in the latched direction, wrapping per period.
  always_comb begin
    pos_step = phase_pos;
    if (updn) pos_step = (phase_pos == POS_MAX) ? '0 : phase_pos + POS_W'(1);
    else      pos_step = (phase_pos == '0) ? POS_MAX : phase_pos - POS_W'(1);
  end

  // Next-state and next-output logic; lock loss overrides everything.
  always_comb begin
    state_nxt  = state;
    tmr_nxt    = tmr;
    rem_nxt    = remaining;
    pos_nxt    = phase_pos;
    updn_nxt   = updn;
    cntsel_nxt = cntsel;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    terr_nxt   = timeout_err;
    lerr_nxt   = lock_err;
    case (state)
      ST_IDLE: begin
        if (busy) begin
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
        end else if (accept) begin
          updn_nxt   = req_updn;
          cntsel_nxt = req_cntsel;
          rem_nxt    = req_steps;
          terr_nxt   = 1'b0;
          lerr_nxt   = 1'b0;
          busy_nxt   = 1'b1;
          if (req_steps != '0) begin
            state_nxt = ST_ASSERT;
            tmr_nxt   = TMR_PE;
          end
        end
      end
      ST_ASSERT: begin
        if (tmr_zero) begin
          state_nxt = ST_WAIT_LOW;
          tmr_nxt   = TMR_TO;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (!pd_s) begin
          state_nxt = ST_WAIT_HIGH;
          tmr_nxt   = TMR_TO;
        end else if (tmr_zero) begin
          terr_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          rem_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      ST_WAIT_HIGH: begin
        if (pd_s) begin
          state_nxt = ST_GAP;
          tmr_nxt   = TMR_GAP;
          rem_nxt   = remaining - STEP_W'(1);
          pos_nxt   = pos_step;
        end else if (tmr_zero) begin
          terr_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          rem_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          if (remaining != '0) begin
            state_nxt = ST_ASSERT;
            tmr_nxt   = TMR_PE;
          end else begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A PLL relock restores the compiled phase, so the tracked offset returns to 0.
    if (!pll_locked) begin
      pos_nxt = '0;
      if (state != ST_IDLE || busy) begin
        lerr_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        rem_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    end
    // Ready only reappears the cycle after done_pulse.
    ready_nxt = pll_locked && (state_nxt == ST_IDLE) && !busy_nxt && !done_nxt;
  end

  // State and output registers.
  always_ff @(posedge scanclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tmr         <= '0;
      remaining   <= '0;
      phase_pos   <= '0;
      updn        <= 1'b0;
      cntsel      <= '0;
      busy        <= 1'b0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
      lock_err    <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      tmr         <= tmr_nxt;
      remaining   <= rem_nxt;
      phase_pos   <= pos_nxt;
      updn        <= updn_nxt;
      cntsel      <= cntsel_nxt;
      busy        <= busy_nxt;
      done_pulse  <= done_nxt;
      timeout_err <= terr_nxt;
      lock_err    <= lerr_nxt;
      req_ready_q <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_gbt_rx_frameclk_phalgnr_dps_ctrl.sv
// Bench for the DPS initiator: PLL handshake model, directed and random requests,
// checked against a modular-arithmetic phase model and per-request pulse counts.
module tb_gbt_rx_frameclk_phalgnr_dps_ctrl;

  localparam int SPP = 144;
  localparam int PE  = 2;
  localparam int TO  = 1023;

  logic       scanclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_updn = 1'b0;
  logic [4:0] req_cntsel = '0;
  logic [7:0] req_steps = '0;
  logic       phase_done = 1'b1;
  logic       req_ready, phase_en, updn, busy, done_pulse, timeout_err, lock_err;
  logic [4:0] cntsel;
  logic [7:0] phase_pos;

  gbt_rx_frameclk_phalgnr_dps_ctrl dut (
    .scanclk(scanclk), .rst(rst), .pll_locked(pll_locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_updn(req_updn),
    .req_cntsel(req_cntsel), .req_steps(req_steps),
    .phase_en(phase_en), .updn(updn), .cntsel(cntsel), .phase_done(phase_done),
    .busy(busy), .done_pulse(done_pulse), .timeout_err(timeout_err),
    .lock_err(lock_err), .phase_pos(phase_pos)
  );

  always #5 scanclk = ~scanclk;

  int checks = 0;
  int errors = 0;
  int model_pos = 0;
  bit pll_mode = 1'b1;
  logic exp_updn = 1'b0;
  logic [4:0] exp_cntsel = '0;

  // PLL model: after each phase_en rise, pull phase_done low for a while, then release.
  logic pe_prev = 1'b0;
  always begin
    @(posedge scanclk);
    #2;
    if (phase_en === 1'b1 && !pe_prev && pll_mode) begin
      repeat ($urandom_range(2, 5)) @(posedge scanclk);
      #2 phase_done = 1'b0;
      repeat ($urandom_range(4, 8)) @(posedge scanclk);
      #2 phase_done = 1'b1;
    end
    pe_prev = phase_en;
  end

  // Monitor: phase_en pulse count/width, done pulses, updn/cntsel stability while busy.
  int pe_pulses = 0, pe_bad_width = 0, pe_run = 0, done_cnt = 0, hold_bad = 0;
  logic pe_last = 1'b0;
  always @(negedge scanclk) begin
    if (phase_en === 1'b1) pe_run <= pe_run + 1;
    else pe_run <= 0;
    if (phase_en === 1'b1 && !pe_last) pe_pulses <= pe_pulses + 1;
    if (phase_en !== 1'b1 && pe_last && pe_run != PE) pe_bad_width <= pe_bad_width + 1;
    if (done_pulse === 1'b1) done_cnt <= done_cnt + 1;
    if (busy === 1'b1 && (updn !== exp_updn || cntsel !== exp_cntsel)) hold_bad <= hold_bad + 1;
    pe_last <= (phase_en === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge scanclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int next_pos(input int p, input bit up, input int n);
    if (up) return (p + n) % SPP;
    return (((p - n) % SPP) + SPP) % SPP;
  endfunction

  task automatic run_req(input bit up, input int cs, input int n, input string tag);
    int p0, d0, b0, h0, cyc;
    cyc = 0;
    while ((req_ready !== 1'b1 || phase_done !== 1'b1) && cyc < 200) begin step(); cyc++; end
    chk({tag, " ready"}, req_ready, 1);
    exp_updn = up;
    exp_cntsel = 5'(cs);
    p0 = pe_pulses; d0 = done_cnt; b0 = pe_bad_width; h0 = hold_bad;
    req_valid = 1'b1; req_updn = up; req_cntsel = 5'(cs); req_steps = 8'(n);
    step();
    req_valid = 1'b0;
    chk({tag, " busy_on_accept"}, busy, 1);
    chk({tag, " phase_en_first"}, phase_en, (n != 0) ? 1 : 0);
    chk({tag, " errs_cleared"}, {timeout_err, lock_err}, 0);
    cyc = 0;
    while (done_pulse !== 1'b1 && timeout_err !== 1'b1 && lock_err !== 1'b1 && cyc < 200 * n + 100) begin
      step(); cyc++;
    end
    chk({tag, " done_pulse"}, done_pulse, 1);
    chk({tag, " busy_at_done"}, busy, 0);
    step(); step();
    model_pos = next_pos(model_pos, up, n);
    chk({tag, " phase_pos"}, phase_pos, model_pos);
    chk({tag, " pulses"}, pe_pulses - p0, n);
    chk({tag, " done_count"}, done_cnt - d0, 1);
    chk({tag, " pe_width_bad"}, pe_bad_width - b0, 0);
    chk({tag, " hold_bad"}, hold_bad - h0, 0);
  endtask

  initial begin
    int cyc, p0, d0;
    bit up;
    int cs, n;

    // Reset values
    repeat (3) step();
    chk("rst req_ready", req_ready, 0);
    chk("rst outputs", {phase_en, updn, cntsel, busy, done_pulse, timeout_err, lock_err}, 0);
    chk("rst phase_pos", phase_pos, 0);
    rst = 1'b0;
    step();
    chk("post_rst req_ready", req_ready, 1);

    // Basic and wrap cases
    run_req(1'b1, 0, 3, "up3");
    run_req(1'b0, 0, 4, "down4_wrap");
    run_req(1'b1, 0, 145, "up145_wrap");

    // Zero-step request
    exp_updn = 1'b0; exp_cntsel = 5'd3;
    p0 = pe_pulses;
    req_valid = 1'b1; req_updn = 1'b0; req_cntsel = 5'd3; req_steps = 8'd0;
    step();
    req_valid = 1'b0;
    chk("zero N busy", busy, 1);
    chk("zero N done", done_pulse, 0);
    step();
    chk("zero N+1 done", done_pulse, 1);
    chk("zero N+1 busy", busy, 0);
    chk("zero N+1 ready", req_ready, 0);
    step();
    chk("zero N+2 done", done_pulse, 0);
    chk("zero N+2 ready", req_ready, 1);
    chk("zero pos", phase_pos, model_pos);
    chk("zero pulses", pe_pulses - p0, 0);

    // Random requests
    for (int i = 0; i < 6; i++) begin
      up = 1'($urandom_range(0, 1));
      cs = $urandom_range(0, 31);
      n = $urandom_range(0, 20);
      run_req(up, cs, n, "rand");
    end

    // Timeout: PLL never drops phase_done
    pll_mode = 1'b0;
    exp_updn = 1'b1; exp_cntsel = 5'd0;
    p0 = pe_pulses; d0 = done_cnt;
    req_valid = 1'b1; req_updn = 1'b1; req_cntsel = 5'd0; req_steps = 8'd3;
    step();
    req_valid = 1'b0;
    cyc = 0;
    while (timeout_err !== 1'b1 && cyc < 1300) begin step(); cyc++; end
    chk("to latency", cyc, PE + TO);
    chk("to busy", busy, 0);
    step(); step();
    chk("to done_count", done_cnt - d0, 0);
    chk("to pulses", pe_pulses - p0, 1);
    chk("to pos", phase_pos, model_pos);
    chk("to ready", req_ready, 1);
    chk("to sticky", timeout_err, 1);
    pll_mode = 1'b1;
    run_req(1'b1, 2, 1, "after_to");

    // Lock loss during step 2 of 5
    exp_updn = 1'b1; exp_cntsel = 5'd0;
    p0 = pe_pulses; d0 = done_cnt;
    req_valid = 1'b1; req_updn = 1'b1; req_cntsel = 5'd0; req_steps = 8'd5;
    step();
    req_valid = 1'b0;
    cyc = 0;
    while ((pe_pulses - p0) < 2 && cyc < 300) begin step(); cyc++; end
    chk("lock reached step2", pe_pulses - p0, 2);
    pll_locked = 1'b0;
    #1;
    chk("lock ready_now", req_ready, 0);
    step();
    model_pos = 0;
    chk("lock phase_en", phase_en, 0);
    chk("lock lock_err", lock_err, 1);
    chk("lock busy", busy, 0);
    chk("lock pos", phase_pos, model_pos);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lock ready_low", req_ready, 0);
    end
    chk("lock done_count", done_cnt - d0, 0);
    pll_locked = 1'b1;
    step(); step();
    chk("relock ready", req_ready, 1);
    run_req(1'b0, 1, 2, "after_lock");

    // Reset during WAIT_HIGH
    exp_updn = 1'b1; exp_cntsel = 5'd5;
    cyc = 0;
    while ((req_ready !== 1'b1 || phase_done !== 1'b1) && cyc < 200) begin step(); cyc++; end
    req_valid = 1'b1; req_updn = 1'b1; req_cntsel = 5'd5; req_steps = 8'd2;
    step();
    req_valid = 1'b0;
    cyc = 0;
    while (phase_done !== 1'b0 && cyc < 200) begin step(); cyc++; end
    chk("rstwh saw_low", phase_done, 0);
    step(); step();
    rst = 1'b1;
    step();
    chk("rstwh outputs", {phase_en, updn, cntsel, busy, done_pulse, timeout_err, lock_err}, 0);
    chk("rstwh pos", phase_pos, 0);
    chk("rstwh ready", req_ready, 0);
    rst = 1'b0;
    model_pos = 0;
    run_req(1'b1, 5, 2, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gbt_rx_frameclk_phalgnr_dps_ctrl.md
# gbt_rx_frameclk_phalgnr_dps_ctrl

Dynamic phase-shift (DPS) initiator for the RX frame-clock phase-aligner PLL (120 MHz ref, 720 MHz VCO, 40 MHz outclk_0). It accepts step requests from the phase-alignment logic, drives the PLL `phase_en`/`updn`/`cntsel` interface one VCO step at a time, waits on `phase_done` per step, and tracks the resulting phase position modulo one 40 MHz period. Sits between the phase detector/alignment FSM and the PLL wrapper, in the `scanclk` domain.

## Interface
Parameters:
- STEP_W, 8, width of requested step count
- POS_W, 8, width of phase position counter
- STEPS_PER_PERIOD, 144, VCO steps per outclk_0 period (25 ns / 173.6 ps)
- PHASE_EN_CYCLES, 2, cycles `phase_en` is held high per step (≥1)
- GAP_CYCLES, 2, idle cycles between consecutive steps (≥1)
- TIMEOUT_CYCLES, 1023, max cycles waiting for each `phase_done` edge

Ports (one clock; reset is synchronous and active-high):
- scanclk  in  1  sole clock, also fed to PLL `scanclk`
- rst  in  1  synchronous active-high reset
- pll_locked  in  1  PLL `locked`
- req_valid  in  1  step request valid
- req_ready  out  1  controller can accept a request
- req_updn  in  1  direction, 1 = advance (up), 0 = retard
- req_cntsel  in  5  counter select (0 = C0 / outclk_0)
- req_steps  in  STEP_W  number of steps, 0 legal
- phase_en  out  1  to PLL
- updn  out  1  to PLL
- cntsel  out  5  to PLL
- phase_done  in  1  from PLL, asynchronous-safe (double-synchronised internally)
- busy  out  1  request in progress
- done_pulse  out  1  one-cycle pulse on request completion
- timeout_err  out  1  sticky, `phase_done` edge not seen in time
- lock_err  out  1  sticky, lock lost during a request
- phase_pos  out  POS_W  current phase offset in steps, 0..STEPS_PER_PERIOD-1

## Operation
- Reset values: req_ready 0 (1 from next cycle if locked), phase_en 0, updn 0, cntsel 0, busy 0, done_pulse 0, timeout_err 0, lock_err 0, phase_pos 0, sync flops 1.
- phase_done passes through 2-flop synchroniser → `pd_s`; all checks use `pd_s`.
- FSM states: IDLE, ASSERT, WAIT_LOW, WAIT_HIGH, GAP.
- IDLE: req_ready = pll_locked. On req_valid&&req_ready: latch updn, cntsel, remaining = req_steps; clear timeout_err and lock_err; busy=1. remaining=0 → done_pulse next cycle, stay IDLE. Else → ASSERT.
- ASSERT: phase_en=1 for PHASE_EN_CYCLES cycles → WAIT_LOW.
- WAIT_LOW: wait pd_s=0 → WAIT_HIGH. WAIT_HIGH: wait pd_s=1 → update phase_pos, remaining−1 → GAP.
- GAP: GAP_CYCLES cycles; remaining>0 → ASSERT, else done_pulse=1, busy=0 → IDLE.
- Timer resets on entry to WAIT_LOW and WAIT_HIGH; reaching TIMEOUT_CYCLES → timeout_err=1, phase_en=0, abort remaining steps, no done_pulse, → IDLE. phase_pos not updated for the timed-out step.
- phase_pos arithmetic: up: pos==STEPS_PER_PERIOD-1 → 0 else +1; down: pos==0 → STEPS_PER_PERIOD-1 else −1. Updated only on completed steps, regardless of cntsel.
- pll_locked=0 in any state: phase_pos←0 (PLL relock restores compiled phase); if not IDLE: lock_err=1, phase_en=0, busy=0, abort, no done_pulse, → IDLE. req_ready=0 while unlocked.
- updn/cntsel outputs held stable from acceptance until return to IDLE; unchanged in IDLE.
- rst mid-request: all outputs to reset values next edge; PLL shift in flight is left to complete.

## Timing
- Accept at edge N → phase_en high edges N+1..N+PHASE_EN_CYCLES.
- pd_s lags phase_done by 2 cycles; phase_pos updates 1 cycle after pd_s rising observed in WAIT_HIGH.
- req_steps=0: done_pulse at N+1, busy high for exactly one cycle.
- Step cost: PHASE_EN_CYCLES + PLL latency + 2×sync + GAP_CYCLES (+1 per state hop).
- done_pulse coincides with busy falling; req_ready returns 1 the cycle after done_pulse.
- Simultaneous timeout and lock loss: lock_err takes priority; timeout_err also set.

## Test plan
- Reset, locked=1, req up ×3 cntsel=0, PLL model pulls phase_done low 4 cycles after phase_en → three 2-cycle phase_en pulses, phase_pos 0→3, one done_pulse, updn=1 held throughout.
- phase_pos=0, request down ×1 → phase_pos=143; then up ×145 → phase_pos=0 (wrap both ways).
- req_steps=0 → no phase_en, done_pulse at N+1, phase_pos unchanged.
- PLL model never drops phase_done → timeout_err after 1023 cycles in WAIT_LOW, no done_pulse, phase_pos unchanged, req_ready 1; next accepted request clears timeout_err.
- Drop pll_locked during step 2 of 5 → phase_en 0 next cycle, lock_err=1, phase_pos=0, req_ready=0 until locked returns.
- Assert rst during WAIT_HIGH → all outputs reset values next edge; new request after rst completes normally.
